srv_ext_arb: RTL



---
 rtl/srv_ext_arb_if.sv | 40 ++++
 rtl/srv_ext_arb.sv | 74 +++++++
 2 files changed

// File: rtl/srv_ext_arb_if.sv
// Bundle of the two requester ports, the srv_mem channel and the timeout status.
// Pure wiring with no latency. Flow control is the req/rsp handshake carried on these signals.
// slave is the arbiter's view of the bundle. master is the view of the requesters and memory.
interface srv_ext_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
);
    logic              p0_req_i;
    logic [ADDR_W-1:0] p0_addr_i;
    logic              p0_rsp_o;
    logic [DATA_W-1:0] p0_data_o;

    logic              p1_req_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic              p1_rsp_o;
    logic [DATA_W-1:0] p1_data_o;

    logic              ext_req_o;
    logic [ADDR_W-1:0] ext_addr_o;
    logic              ext_rsp_i;
    logic [DATA_W-1:0] ext_data_i;

    logic [1:0]        gnt_o;
    logic              timeout_o;
    logic              timeout_clr_i;

    modport slave (
        input  p0_req_i, p0_addr_i, p1_req_i, p1_addr_i,
        input  ext_rsp_i, ext_data_i, timeout_clr_i,
        output p0_rsp_o, p0_data_o, p1_rsp_o, p1_data_o,
        output ext_req_o, ext_addr_o, gnt_o, timeout_o
    );

    modport master (
        output p0_req_i, p0_addr_i, p1_req_i, p1_addr_i,
        output ext_rsp_i, ext_data_i, timeout_clr_i,
        input  p0_rsp_o, p0_data_o, p1_rsp_o, p1_data_o,
        input  ext_req_o, ext_addr_o, gnt_o, timeout_o
    );
endinterface

// File: rtl/srv_ext_arb.sv
// Round-robin arbiter that serialises two refill requesters onto the single srv_mem channel.
// Grant is registered one cycle after a request. The response passes through to the requester in the same cycle.
// A requester holds req until its rsp pulse. A busy channel defers the other port. The timeout aborts a hung transaction.
module srv_ext_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    srv_ext_arb_if.slave bus
);
    localparam logic [0:0]  S_IDLE  = 1'b0;
    localparam logic [0:0]  S_BUSY  = 1'b1;
    localparam logic [15:0] TMO_VAL = 16'(TIMEOUT);

    logic [0:0]  state;
    logic        last;
    logic [15:0] cnt;
    logic        win;
    logic        busy;
    logic        tmo_hit;
    logic        done;

    // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
    assign win     = bus.p1_req_i & (~bus.p0_req_i | ~last);
    assign busy    = (state == S_BUSY);
    assign tmo_hit = (TIMEOUT != 0) && busy && !bus.ext_rsp_i && (cnt == TMO_VAL);
    assign done    = busy && (bus.ext_rsp_i || tmo_hit);

    assign bus.p0_rsp_o  = done && bus.gnt_o[0];
    assign bus.p1_rsp_o  = done && bus.gnt_o[1];
    assign bus.p0_data_o = (busy && bus.gnt_o[0] && bus.ext_rsp_i) ? bus.ext_data_i : '0;
    assign bus.p1_data_o = (busy && bus.gnt_o[1] && bus.ext_rsp_i) ? bus.ext_data_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            last           <= 1'b1;
            cnt            <= 16'd0;
            bus.gnt_o      <= 2'b00;
            bus.ext_req_o  <= 1'b0;
            bus.ext_addr_o <= '0;
        end else if (state == S_IDLE) begin
            if (bus.p0_req_i || bus.p1_req_i) begin
                state          <= S_BUSY;
                last           <= win;
                cnt            <= 16'd0;
                bus.gnt_o      <= win ? 2'b10 : 2'b01;
                bus.ext_req_o  <= 1'b1;
                bus.ext_addr_o <= win ? bus.p1_addr_i : bus.p0_addr_i;
            end
        end else begin
            if (done) begin
                state         <= S_IDLE;
                bus.gnt_o     <= 2'b00;
                bus.ext_req_o <= 1'b0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // A timeout in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.timeout_o <= 1'b0;
        end else if (tmo_hit) begin
            bus.timeout_o <= 1'b1;
        end else if (bus.timeout_clr_i) begin
            bus.timeout_o <= 1'b0;
        end
    end
endmodule
